// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone sum stage: default width, FSM encoding, result payload.
// Optional signed-overflow tracking is enabled with KS_OVF_DETECT_EN.
package ks_pkg;

  localparam int unsigned KS_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    KS_EMPTY = 2'd0,
    KS_ONE   = 2'd1,
    KS_FULL  = 2'd2
  } ks_state_t;

  // Result payload at the default width; the stage re-declares it for its own W.
  typedef struct packed {
    logic [KS_W_DEFAULT-1:0] sum;
    logic                    cout;
    logic                    ovf;
  } ks_result_t;

endpackage

// File: rtl/ks_sum_stage_if.sv
// Valid/ready bundle between the prefix tree, the sum stage and its consumer.
// master = producer/consumer side (testbench or upstream), slave = ks_sum_stage.
interface ks_sum_stage_if
  import ks_pkg::*;
#(
  parameter int unsigned W = KS_W_DEFAULT
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] p_bit;
  logic [W-1:0] g_grp;
  logic [W-1:0] p_grp;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, p_bit, g_grp, p_grp, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, p_bit, g_grp, p_grp, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/ks_carry_fold.sv
// Folds carry-in into the group generate/propagate terms and forms sum, carry-out and
// (with KS_OVF_DETECT_EN) signed overflow. Purely combinational.
module ks_carry_fold
  import ks_pkg::*;
#(
  parameter int unsigned W = KS_W_DEFAULT
) (
  input  logic [W-1:0] p_bit_i,
  input  logic [W-1:0] g_grp_i,
  input  logic [W-1:0] p_grp_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_c_o,
`ifdef KS_OVF_DETECT_EN
  output logic         ovf_c_o,
`endif
  output logic         cout_c_o
);

  // carry_c[i] is the carry into bit i; carry_c[W] leaves the adder.
  logic [W:0] carry_c;

  assign carry_c  = {g_grp_i | (p_grp_i & {W{cin_i}}), cin_i};
  assign sum_c_o  = p_bit_i ^ carry_c[W-1:0];
  assign cout_c_o = carry_c[W];

`ifdef KS_OVF_DETECT_EN
  assign ovf_c_o  = carry_c[W] ^ carry_c[W-1];
`endif

endmodule

// File: rtl/ks_sum_stage.sv
// Registered final stage of the Kogge-Stone adder with a 2-entry skid buffer.
// Define KS_OVF_DETECT_EN to store and report signed overflow; otherwise ovf is tied low.
module ks_sum_stage
  import ks_pkg::*;
#(
  parameter int unsigned W = KS_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  ks_sum_stage_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'(KS_EMPTY);
  localparam logic [1:0] ST_ONE   = 2'(KS_ONE);
  localparam logic [1:0] ST_FULL  = 2'(KS_FULL);

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
`ifdef KS_OVF_DETECT_EN
    logic         ovf;
`endif
  } res_t;

  logic [1:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  res_t       main_q, main_d;
  res_t       skid_q, skid_d;
  res_t       fold_c;
  logic       in_fire_c;
  logic       out_fire_c;

  ks_carry_fold #(
    .W (W)
  ) u_fold (
    .p_bit_i  (bus.p_bit),
    .g_grp_i  (bus.g_grp),
    .p_grp_i  (bus.p_grp),
    .cin_i    (bus.cin),
    .sum_c_o  (fold_c.sum),
`ifdef KS_OVF_DETECT_EN
    .ovf_c_o  (fold_c.ovf),
`endif
    .cout_c_o (fold_c.cout)
  );

  assign in_fire_c  = bus.in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & bus.out_ready;

  // Next state, buffer movement and registered handshake flags.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          state_d = ST_ONE;
          main_d  = fold_c;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = fold_c;
        end else if (in_fire_c) begin
          state_d = ST_FULL;
          skid_d  = fold_c;
        end else if (out_fire_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = main_q.sum;
  assign bus.cout      = main_q.cout;
`ifdef KS_OVF_DETECT_EN
  assign bus.ovf       = main_q.ovf;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sum_stage.sv
// Scoreboard bench for ks_sum_stage at W=8; operands are turned into prefix-tree inputs
// by a ripple reference, expected results come from plain a+b+cin arithmetic.
module tb_ks_sum_stage;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  ks_sum_stage_if #(.W(W)) bus ();

  ks_sum_stage #(.W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  // Expected entry: {sum, cout, ovf}
  logic [W+1:0] sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Prefix-tree reference: group terms over bits [i:0] with cin excluded.
  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W-1:0] pb, gb, gg, pg;
    logic g, p;
    pb = a ^ b;
    gb = a & b;
    g = 1'b0;
    p = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      g = gb[i] | (pb[i] & g);
      p = p & pb[i];
      gg[i] = g;
      pg[i] = p;
    end
    bus.p_bit = pb;
    bus.g_grp = gg;
    bus.p_grp = pg;
    bus.cin   = ci;
  endtask

  function automatic logic [W+1:0] expect_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci);
    logic [W:0] full;
    logic ov;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
`ifdef KS_OVF_DETECT_EN
    ov = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
    ov = 1'b0;
`endif
    return {full[W-1:0], full[W], ov};
  endfunction

  // One clock: drive at negedge, resolve fires just after, transfers happen at next posedge.
  task automatic cycle(input logic r, input logic iv, input logic ordy,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic acc);
    logic [W+1:0] e;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    drive_ops(a, b, ci);
    #1;
    acc = iv && bus.in_ready && !r;
    if (r) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && ordy) begin
        n_out++;
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_sum", 32'(bus.sum), 32'(e[W+1:2]));
          check_val("sb_cout", 32'(bus.cout), 32'(e[1]));
          check_val("sb_ovf", 32'(bus.ovf), 32'(e[0]));
        end
      end
      if (acc) sb_q.push_back(expect_of(a, b, ci));
    end
  endtask

  // Hold an operation valid until it is accepted, within a bounded number of cycles.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      cycle(1'b0, 1'b1, ordy, a, b, ci, acc);
      n++;
    end
    if (!acc) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, acc);
      n++;
    end
    check_val("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    int   n0, both_cnt, acc_cnt;

    // Reset held for two edges with a valid operand presented.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    drive_ops(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sum", 32'(bus.sum), 32'd0);
    check_val("rst_cout", 32'(bus.cout), 32'd0);
    check_val("rst_ovf", 32'(bus.ovf), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Basic add with single-cycle latency.
    cycle(1'b0, 1'b1, 1'b1, 8'h3C, 8'h05, 1'b0, acc);
    check_val("basic_acc", 32'(acc), 32'd1);
    @(negedge clk);
    check_val("basic_valid", 32'(bus.out_valid), 32'd1);
    check_val("basic_sum", 32'(bus.sum), 32'h41);
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, acc);

    // Wrap-around and signed overflow.
    send(8'hFF, 8'h00, 1'b1, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 1'b1);
    drain();

    // Backpressure: two accepted, third stalls while FULL.
    cycle(1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, acc);
    check_val("bp_acc1", 32'(acc), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'd2, 8'd2, 1'b0, acc);
    check_val("bp_acc2", 32'(acc), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'd3, 8'd3, 1'b0, acc);
    check_val("bp_acc3_blocked", 32'(acc), 32'd0);
    check_val("bp_full_ready", 32'(bus.in_ready), 32'd0);
    check_val("bp_hold_sum", 32'(bus.sum), 32'h02);
    n0 = n_out;
    send(8'd3, 8'd3, 1'b0, 1'b1);
    drain();
    check_val("bp_out_count", 32'(n_out - n0), 32'd3);

    // Simultaneous in/out fire while in ONE.
    send(8'd5, 8'd6, 1'b0, 1'b1);
    n0 = n_out;
    both_cnt = 0;
    acc_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), acc);
      if (acc) acc_cnt++;
      if (bus.in_ready && bus.out_valid) both_cnt++;
    end
    check_val("simul_acc", 32'(acc_cnt), 32'd100);
    check_val("simul_one", 32'(both_cnt), 32'd100);
    check_val("simul_out", 32'(n_out - n0), 32'd100);
    drain();

    // Random traffic with a mid-stream reset pulse.
    for (int i = 0; i < 10000; i++) begin
      cycle((i == 5000 || i == 5001), 1'($urandom), ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom), 1'($urandom), acc);
      if (i == 5002) begin
        check_val("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("flush_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
